zorro_autoconfig: RTL
=====================

Name: zorro_autoconfig

Overview:
- Zorro II AutoConfig responder for the RIPPLE-IDE card; sits directly upstream of the IDE decode/strobe block and produces its `ide_access` select.
- While unconfigured and CFGIN_n is asserted, it presents the board's nibble-wide configuration ROM at $E80000 and latches the base address the host assigns.
- Once configured, it decodes the card's 128K window and drives CFGOUT_n to the next board in the chain.

Parameters:
- MANUF_ID, 16'h082C, Zorro manufacturer ID.
- PROD_ID, 8'd7, product number.
- SERIAL, 32'h0000_0000, serial number.
- SIZE_CODE, 3'b010, Zorro II size code (010 = 128K).
- ROM_VEC, 16'h4000, boot ROM vector offset (er_InitDiagVec).

Ports:
- CLK  in  1  bus clock (7 MHz CPU clock).
- RESET_n  in  1  asynchronous active-low reset.
- ADDR  in  23  CPU address A[23:1].
- DBUS  inout  4  data D[15:12]; nibble read data / write data.
- AS_n  in  1  address strobe.
- UDS_n  in  1  upper data strobe.
- LDS_n  in  1  lower data strobe.
- RW  in  1  1 = read.
- CFGIN_n  in  1  AutoConfig enable from the previous board.
- CFGOUT_n  out  1  AutoConfig enable to the next board.
- ide_access  out  1  card window hit (feeds the IDE block).
- cfg_access  out  1  AutoConfig space hit (for the ROM/DTACK logic).
- configured  out  1  base address assigned.

Behaviour:
- Reset: already decided — RESET_n is asynchronous and active-low; clock is CLK. In reset, state = UNCFG, base = 8'h00, CFGOUT_n = 1, ide_access = 0, cfg_access = 0, configured = 0, DBUS = Z.
- States:
  - UNCFG: responding.
  - CONFIGURED: base valid.
  - SHUTUP: permanently silent until reset.
  - No other transitions; only reset leaves CONFIGURED or SHUTUP.
- cfg_access (combinational): !AS_n && !CFGIN_n && state == UNCFG && ADDR[23:16] == 8'hE8.
- ROM byte index = ADDR[7:2]; ADDR[1] selects the nibble (0 = high nibble [7:4], 1 = low nibble [3:0]).
- Raw ROM bytes:
  - 00 = {2'b11, 1'b0, 1'b1 (ROM vector valid), 1'b0, SIZE_CODE}.
  - 04 = PROD_ID.
  - 08 = 8'h00.
  - 10/14 = MANUF_ID hi/lo.
  - 18..24 = SERIAL, MSB first.
  - 28/2C = ROM_VEC hi/lo.
  - All other indices = 8'h00.
- Read data: every byte except index 00 is driven inverted (~nibble); index 00 is driven true.
- DBUS drive: active only when cfg_access && RW && (!UDS_n || !LDS_n); Z otherwise. The drive is combinational, so it releases the same cycle AS_n negates.
- Write capture: on posedge CLK with cfg_access && !RW && !UDS_n, exactly once per bus cycle.
  - An internal wr_done flag is set on capture and cleared while AS_n = 1.
  - A write held over several clocks updates state only once.
- Write registers:
  - Offset $4A (index 12, ADDR[1] = 1): base[3:0] <= DBUS. No state change.
  - Offset $48 (index 12, ADDR[1] = 0): base[7:4] <= DBUS, then state -> CONFIGURED. This write completes configuration.
  - Offset $4C (either nibble): state -> SHUTUP.
  - Writes to any other offset are ignored.
- Sequencing: the host writes $4A before $48. A lone $48 write configures with base[3:0] = 0.
- CFGOUT_n: registered; goes to 0 on the clock after entering CONFIGURED or SHUTUP, and returns to 1 only on reset.
- configured = (state == CONFIGURED).
- ide_access (combinational): configured && !AS_n && ADDR[23:17] == base[7:1]. base[0] is ignored because the window is 128K-aligned.
- CFGIN_n rising while in UNCFG: the block stops responding immediately, and state is retained.
- Reset asserted mid-cycle: DBUS floats and everything returns to reset values at once.

Decomposition:
- Shared package `zorro_pkg`:
  - size codes: SZ_64K, SZ_128K, …
  - ER_TYPE_Z2 = 2'b11.
  - AutoConfig offsets: AC_BASE = 8'hE8, AC_REG_BASE_HI = 6'h12, AC_REG_SHUTUP = 6'h13.
  - State enum: UNCFG, CONFIGURED, SHUTUP.
- One sub-module, `autoconfig_rom`: purely combinational; maps index, nibble select and parameters to the nibble, including the inversion. The top level holds the FSM, write capture, decode and tristate.

Test Plan:
- Reset, CFGIN_n = 0, read $E80000 and $E80002 → DBUS = 4'hD, 4'h2. Read $E80004 and $E80006 (PROD_ID = 7) → 4'hF, 4'h8. Read $E80010 (MANUF hi = 8'h08) → 4'hF.
- Write 4'h2 to $E8004A, then 4'hE to $E80048 → configured = 1, CFGOUT_n = 0 one CLK later.
  - Access $E30000 → ide_access = 1.
  - Access $E40000 and $E1FFFE → ide_access = 0.
  - Further $E8xxxx reads → DBUS = Z, cfg_access = 0.
- Write to $E8004C → SHUTUP: CFGOUT_n = 0, configured = 0, ide_access stays 0 for any address, cfg_access = 0.
- CFGIN_n = 1, read $E80000 → cfg_access = 0, DBUS = Z. Write $E80048 → no state change.
- $E80048 write with AS_n held low for 4 CLKs and DBUS changing on clock 3 → base[7:4] holds the first-clock value; single transition.
- Pulse RESET_n low in the middle of a configured access → ide_access = 0, CFGOUT_n = 1, state = UNCFG; reads at $E80000 return 4'hD again.

Source files
------------

// File: rtl/zorro_pkg.sv
// Shared constants and types for the Zorro II AutoConfig responder.
// Size codes, ER type field, AutoConfig register offsets and the config-state enum.
package zorro_pkg;

  localparam logic [2:0] SZ_8M   = 3'b000;
  localparam logic [2:0] SZ_64K  = 3'b001;
  localparam logic [2:0] SZ_128K = 3'b010;
  localparam logic [2:0] SZ_256K = 3'b011;
  localparam logic [2:0] SZ_512K = 3'b100;
  localparam logic [2:0] SZ_1M   = 3'b101;
  localparam logic [2:0] SZ_2M   = 3'b110;
  localparam logic [2:0] SZ_4M   = 3'b111;

  localparam logic [1:0] ER_TYPE_Z2 = 2'b11;

  localparam logic [7:0] AC_BASE        = 8'hE8;
  localparam logic [5:0] AC_REG_BASE_HI = 6'h12;
  localparam logic [5:0] AC_REG_SHUTUP  = 6'h13;

  // ROM byte indices (byte offset / 4) of the read-only AutoConfig registers.
  localparam logic [5:0] ROM_IDX_TYPE    = 6'h00;
  localparam logic [5:0] ROM_IDX_PROD    = 6'h01;
  localparam logic [5:0] ROM_IDX_FLAGS   = 6'h02;
  localparam logic [5:0] ROM_IDX_MANUF_H = 6'h04;
  localparam logic [5:0] ROM_IDX_MANUF_L = 6'h05;
  localparam logic [5:0] ROM_IDX_SER_3   = 6'h06;
  localparam logic [5:0] ROM_IDX_SER_2   = 6'h07;
  localparam logic [5:0] ROM_IDX_SER_1   = 6'h08;
  localparam logic [5:0] ROM_IDX_SER_0   = 6'h09;
  localparam logic [5:0] ROM_IDX_VEC_H   = 6'h0A;
  localparam logic [5:0] ROM_IDX_VEC_L   = 6'h0B;

  typedef enum logic [1:0] {
    UNCFG      = 2'd0,
    CONFIGURED = 2'd1,
    SHUTUP     = 2'd2
  } ac_state_e;

  function automatic logic [7:0] er_type_byte(input logic [2:0] size_code);
    return {ER_TYPE_Z2, 1'b0, 1'b1, 1'b0, size_code};
  endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig ROM: byte index + nibble select -> bus nibble.
// Every byte except the type byte at index 0 is presented inverted, as the host expects.
module autoconfig_rom
  import zorro_pkg::*;
#(
  parameter logic [15:0] MANUF_ID  = 16'h082C,
  parameter logic [7:0]  PROD_ID   = 8'd7,
  parameter logic [31:0] SERIAL    = 32'h0000_0000,
  parameter logic [2:0]  SIZE_CODE = SZ_128K,
  parameter logic [15:0] ROM_VEC   = 16'h4000
) (
  input  logic [5:0] i_index,
  input  logic       i_nib_lo,
  output logic [3:0] o_nib
);

  logic [7:0] w_byte;
  logic [3:0] w_nib_true;

  always_comb begin
    w_byte = 8'h00;
    case (i_index)
      ROM_IDX_TYPE:    w_byte = er_type_byte(SIZE_CODE);
      ROM_IDX_PROD:    w_byte = PROD_ID;
      ROM_IDX_FLAGS:   w_byte = 8'h00;
      ROM_IDX_MANUF_H: w_byte = MANUF_ID[15:8];
      ROM_IDX_MANUF_L: w_byte = MANUF_ID[7:0];
      ROM_IDX_SER_3:   w_byte = SERIAL[31:24];
      ROM_IDX_SER_2:   w_byte = SERIAL[23:16];
      ROM_IDX_SER_1:   w_byte = SERIAL[15:8];
      ROM_IDX_SER_0:   w_byte = SERIAL[7:0];
      ROM_IDX_VEC_H:   w_byte = ROM_VEC[15:8];
      ROM_IDX_VEC_L:   w_byte = ROM_VEC[7:0];
      default:         w_byte = 8'h00;
    endcase
  end

  assign w_nib_true = i_nib_lo ? w_byte[3:0] : w_byte[7:4];
  assign o_nib      = (i_index == ROM_IDX_TYPE) ? w_nib_true : ~w_nib_true;

endmodule

// File: rtl/zorro_autoconfig.sv
// Zorro II AutoConfig responder for the RIPPLE-IDE card: config ROM, base latch, window decode.
// Decodes are combinational on the bus strobes; state, base and CFGOUT_n are registered on CLK.
module zorro_autoconfig
  import zorro_pkg::*;
#(
  parameter logic [15:0] MANUF_ID  = 16'h082C,
  parameter logic [7:0]  PROD_ID   = 8'd7,
  parameter logic [31:0] SERIAL    = 32'h0000_0000,
  parameter logic [2:0]  SIZE_CODE = SZ_128K,
  parameter logic [15:0] ROM_VEC   = 16'h4000
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [23:1] ADDR,
  inout  wire  [3:0]  DBUS,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic        CFGIN_n,
  output logic        CFGOUT_n,
  output logic        ide_access,
  output logic        cfg_access,
  output logic        configured
);

  ac_state_e  r_state;
  logic [7:0] r_base;
  logic       r_wr_done;
  logic       r_cfgout_n;

  logic       w_cfg_access;
  logic       w_rd_drive;
  logic       w_wr_hit;
  logic [3:0] w_rom_nib;
  logic [5:0] w_reg_idx;
  logic       w_unused_addr;

  assign w_reg_idx     = ADDR[7:2];
  assign w_unused_addr = ^ADDR[15:8];

  // RESET_n gates the decodes so the bus is released the instant reset asserts.
  assign w_cfg_access = RESET_n && !AS_n && !CFGIN_n && (r_state == UNCFG)
                        && (ADDR[23:16] == AC_BASE);
  assign w_rd_drive   = w_cfg_access && RW && (!UDS_n || !LDS_n);
  assign w_wr_hit     = w_cfg_access && !RW && !UDS_n && !r_wr_done;

  autoconfig_rom #(
    .MANUF_ID  (MANUF_ID),
    .PROD_ID   (PROD_ID),
    .SERIAL    (SERIAL),
    .SIZE_CODE (SIZE_CODE),
    .ROM_VEC   (ROM_VEC)
  ) u_rom (
    .i_index  (w_reg_idx),
    .i_nib_lo (ADDR[1]),
    .o_nib    (w_rom_nib)
  );

  assign DBUS = w_rd_drive ? w_rom_nib : 4'bzzzz;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= UNCFG;
      r_base     <= 8'h00;
      r_wr_done  <= 1'b0;
      r_cfgout_n <= 1'b1;
    end else begin
      // One capture per bus cycle: the flag blocks repeats until AS_n negates.
      if (AS_n) begin
        r_wr_done <= 1'b0;
      end else if (w_wr_hit) begin
        r_wr_done <= 1'b1;
      end

      if (w_wr_hit) begin
        case (w_reg_idx)
          AC_REG_BASE_HI: begin
            if (ADDR[1]) begin
              r_base[3:0] <= DBUS;
            end else begin
              r_base[7:4] <= DBUS;
              r_state     <= CONFIGURED;
            end
          end
          AC_REG_SHUTUP: r_state <= SHUTUP;
          default: ;
        endcase
      end

      if (r_state != UNCFG) begin
        r_cfgout_n <= 1'b0;
      end
    end
  end

  assign CFGOUT_n   = r_cfgout_n;
  assign cfg_access = w_cfg_access;
  assign configured = (r_state == CONFIGURED);
  assign ide_access = RESET_n && configured && !AS_n && (ADDR[23:17] == r_base[7:1]);

endmodule
